// File: rtl/press_count_pkg.sv
// Shared constants and helpers for the press counter controller.
// Button index map, debounce counter width and the fixed-priority pick.
package press_count_pkg;

  localparam int NUM_BTN  = 3;
  localparam int IDX_UP   = 0;
  localparam int IDX_DOWN = 1;
  localparam int IDX_CLR  = 2;
  localparam int SC_W     = 8;

  // One-hot pick of the highest-priority pending request: clr > up > down.
  function automatic logic [NUM_BTN-1:0] grant_pick(input logic [NUM_BTN-1:0] p);
    logic [NUM_BTN-1:0] g;
    g = '0;
    if (p[IDX_CLR])       g[IDX_CLR]  = 1'b1;
    else if (p[IDX_UP])   g[IDX_UP]   = 1'b1;
    else if (p[IDX_DOWN]) g[IDX_DOWN] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/press_count_ctrl_if.sv
// Button/count bundle for press_count_ctrl.
// The master side drives the raw buttons; the slave side is the controller.
// Defining PRESS_COUNT_SATURATE_EN adds the sat pulse output.
interface press_count_ctrl_if #(
  parameter int WIDTH = 4
);
  import press_count_pkg::*;

  logic                btn_up;
  logic                btn_down;
  logic                btn_clr;
  logic [WIDTH-1:0]    count;
  logic [NUM_BTN-1:0]  pend;
  logic [NUM_BTN-1:0]  grant;
  logic [NUM_BTN-1:0]  db_level;
`ifdef PRESS_COUNT_SATURATE_EN
  logic                sat;

  modport master (
    output btn_up, btn_down, btn_clr,
    input  count, pend, grant, db_level, sat
  );
  modport slave (
    input  btn_up, btn_down, btn_clr,
    output count, pend, grant, db_level, sat
  );
`else
  modport master (
    output btn_up, btn_down, btn_clr,
    input  count, pend, grant, db_level
  );
  modport slave (
    input  btn_up, btn_down, btn_clr,
    output count, pend, grant, db_level
  );
`endif

endinterface

// File: rtl/press_count_ctrl_btn_debounce.sv
// Per-button synchroniser, stability counter and debounced level.
// level flips only after DB_CYCLES consecutive synchronised samples differ
// from it; rise flags the edge on which level goes 0->1.
module btn_debounce
  import press_count_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [SC_W-1:0] sc;
  logic            accept;

  // The differing sample has been stable long enough: level takes it this edge.
  assign accept = (sync2 != level) && (sc == SC_LAST);
  assign rise   = accept && sync2;

  // Two-flop synchroniser followed by the stability counter and level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sc    <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == level) begin
        sc <= '0;
      end else if (accept) begin
        level <= sync2;
        sc    <= '0;
      end else begin
        sc <= sc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/press_count_ctrl.sv
// Debounce-and-arbitration controller for the shared press counter.
// Each debounced rising edge becomes a pending request; a fixed-priority
// arbiter (clr > up > down) applies at most one request per cycle.
// Request semantics: a pend bit is the request, it is consumed on the edge
// its grant is registered, and a new edge landing on that same edge keeps
// it set so the fresh request is served later.
// Optional macro PRESS_COUNT_SATURATE_EN: saturating up/down with a sat pulse.
module press_count_ctrl
  import press_count_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  press_count_ctrl_if.slave bus
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] db_level;
  logic [NUM_BTN-1:0] rise_db;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pend_q;
  logic [NUM_BTN-1:0] pend_d;
  logic [NUM_BTN-1:0] grant_q;
  logic [NUM_BTN-1:0] grant_d;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   count_d;
`ifdef PRESS_COUNT_SATURATE_EN
  logic               sat_q;
  logic               sat_d;
`endif

  assign btn_raw[IDX_UP]   = bus.btn_up;
  assign btn_raw[IDX_DOWN] = bus.btn_down;
  assign btn_raw[IDX_CLR]  = bus.btn_clr;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[i]),
      .level (db_level[i]),
      .rise  (rise_db[i])
    );
  end

  // Combined edge pulses feeding the request flags.
  assign rise = rise_db;

  // Pick one request, compute the new count and the surviving request flags.
  always_comb begin
    grant_d = grant_pick(pend_q);
    count_d = count_q;
`ifdef PRESS_COUNT_SATURATE_EN
    sat_d   = 1'b0;
`endif
    if (grant_d[IDX_CLR]) begin
      count_d = '0;
    end else if (grant_d[IDX_UP]) begin
`ifdef PRESS_COUNT_SATURATE_EN
      if (&count_q) sat_d   = 1'b1;
      else          count_d = count_q + WIDTH'(1);
`else
      count_d = count_q + WIDTH'(1);
`endif
    end else if (grant_d[IDX_DOWN]) begin
`ifdef PRESS_COUNT_SATURATE_EN
      if (count_q == '0) sat_d   = 1'b1;
      else               count_d = count_q - WIDTH'(1);
`else
      count_d = count_q - WIDTH'(1);
`endif
    end
    // A rising edge on the same edge as its grant wins, so the request survives.
    pend_d = (pend_q & ~grant_d) | rise;
  end

  // Registered grant, count and request flags; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      grant_q <= '0;
      count_q <= '0;
`ifdef PRESS_COUNT_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      pend_q  <= pend_d;
      grant_q <= grant_d;
      count_q <= count_d;
`ifdef PRESS_COUNT_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.count    = count_q;
  assign bus.pend     = pend_q;
  assign bus.grant    = grant_q;
  assign bus.db_level = db_level;
`ifdef PRESS_COUNT_SATURATE_EN
  assign bus.sat      = sat_q;
`endif

endmodule

// File: tb/tb_press_count_ctrl.sv
// Self-checking bench for press_count_ctrl: directed button scenarios plus
// randomized bouncy traffic, compared against a per-cycle reference model.
module tb_press_count_ctrl;

  localparam int WIDTH = 4;
  localparam int DB    = 4;
  localparam int MODV  = 1 << WIDTH;
  localparam int MAXV  = MODV - 1;
  localparam int SB_W  = 10 + WIDTH;
`ifdef PRESS_COUNT_SATURATE_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic clk;
  logic rst;

  press_count_ctrl_if #(.WIDTH(WIDTH)) bus ();

  press_count_ctrl #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per button: a run length of consecutive synchronised samples that differ
  // from the accepted level; the level flips after DB of them in a row.
  logic [SB_W-1:0] exp_q[$];
  logic [2:0]      hist_q[$];
  int              run_m[3];
  logic [2:0]      lvl_m, pend_m, grant_m, force_rise_m;
  bit              sat_m;
  int              cnt_m;
  bit              model_valid = 1'b0;

  task automatic model_step();
    logic [2:0] raw, s, rz;
    raw = {bus.btn_clr, bus.btn_down, bus.btn_up};
    if (rst) begin
      lvl_m = '0; pend_m = '0; grant_m = '0; sat_m = 1'b0; cnt_m = 0;
      for (int b = 0; b < 3; b++) run_m[b] = 0;
      hist_q = {3'b000, 3'b000};
      model_valid = 1'b1;
    end else if (model_valid) begin
      s = hist_q.pop_front();
      hist_q.push_back(raw);
      rz = '0;
      for (int b = 0; b < 3; b++) begin
        if (s[b] != lvl_m[b]) begin
          run_m[b]++;
          if (run_m[b] == DB) begin
            lvl_m[b] = s[b];
            run_m[b] = 0;
            if (s[b]) rz[b] = 1'b1;
          end
        end else begin
          run_m[b] = 0;
        end
      end
      rz = rz | force_rise_m;
      grant_m = '0;
      sat_m   = 1'b0;
      if (pend_m[2]) begin
        grant_m = 3'b100;
        cnt_m   = 0;
      end else if (pend_m[0]) begin
        grant_m = 3'b001;
        if (SAT_BUILD && cnt_m == MAXV) sat_m = 1'b1;
        else cnt_m = (cnt_m + 1) % MODV;
      end else if (pend_m[1]) begin
        grant_m = 3'b010;
        if (SAT_BUILD && cnt_m == 0) sat_m = 1'b1;
        else cnt_m = (cnt_m + MODV - 1) % MODV;
      end
      pend_m = (pend_m & ~grant_m) | rz;
    end
    if (model_valid)
      exp_q.push_back({sat_m, grant_m, pend_m, lvl_m, WIDTH'(cnt_m)});
  endtask

  initial begin
    force_rise_m = '0;
    hist_q = {3'b000, 3'b000};
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Scoreboard: one expected snapshot per edge, compared on the falling edge.
  initial begin
    logic [SB_W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count",    32'(bus.count),    32'(e[WIDTH-1:0]));
        check("db_level", 32'(bus.db_level), 32'(e[WIDTH+2:WIDTH]));
        check("pend",     32'(bus.pend),     32'(e[WIDTH+5:WIDTH+3]));
        check("grant",    32'(bus.grant),    32'(e[WIDTH+8:WIDTH+6]));
`ifdef PRESS_COUNT_SATURATE_EN
        check("sat",      32'(bus.sat),      32'(e[WIDTH+9]));
`endif
      end
    end
  end

  // Pulse counters used by the directed scenarios.
  int up_grants  = 0;
  int sat_pulses = 0;
  initial forever begin
    @(negedge clk);
    if (bus.grant[0] === 1'b1) up_grants++;
`ifdef PRESS_COUNT_SATURATE_EN
    if (bus.sat === 1'b1) sat_pulses++;
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic set_btns(input logic [2:0] v);
    bus.btn_up   = v[0];
    bus.btn_down = v[1];
    bus.btn_clr  = v[2];
  endtask

  // Bounce for 50 ns (toggle every 5 ns), hold 500 ns, release, idle 500 ns.
  task automatic press_bouncy(input logic [2:0] mask);
    @(negedge clk);
    #2;
    for (int i = 0; i < 10; i++) begin
      set_btns((i % 2 == 0) ? mask : 3'b000);
      #5;
    end
    set_btns(mask);
    #500;
    set_btns(3'b000);
    #500;
  endtask

  task automatic press_clean(input logic [2:0] mask);
    @(negedge clk);
    #2;
    set_btns(mask);
    repeat (10) @(negedge clk);
    #2;
    set_btns(3'b000);
    repeat (10) @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, g0, s0;
    bit seen;
    rst = 1'b1;
    set_btns(3'b000);

    // Reset held for several edges while the buttons chatter.
    #2;
    for (int i = 0; i < 16; i++) begin
      set_btns(3'($urandom_range(0, 7)));
      #5;
    end
    set_btns(3'b000);
    @(negedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_pend",  32'(bus.pend),  32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    rst = 1'b0;
    settle(12);
    check("rst_release_count", 32'(bus.count), 32'd0);
    check("rst_release_pend",  32'(bus.pend),  32'd0);

    // Bouncy up presses: exactly one increment each.
    g0 = up_grants;
    press_bouncy(3'b001);
    settle(1);
    check("bouncy_one_grant", 32'(up_grants - g0), 32'd1);
    check("bouncy_count1",    32'(bus.count),      32'd1);
    press_bouncy(3'b001);
    press_bouncy(3'b001);
    settle(1);
    check("bouncy_count3", 32'(bus.count), 32'd3);

    // Two-cycle glitch on down never becomes a debounced level.
    c0 = cnt_m;
    @(negedge clk);
    #2;
    set_btns(3'b010);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("glitch_db_level", 32'(bus.db_level[1]), 32'd0);
    end
    #1;
    set_btns(3'b000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("glitch_db_level", 32'(bus.db_level[1]), 32'd0);
    end
    check("glitch_count", 32'(bus.count), 32'(c0));

    // Wrap / saturate at both ends.
    press_clean(3'b100);
    for (int i = 0; i < 16; i++) press_clean(3'b001);
    settle(1);
    check("wrap_up", 32'(bus.count), SAT_BUILD ? 32'(MAXV) : 32'd0);
    press_clean(3'b100);
    s0 = sat_pulses;
    press_clean(3'b010);
    settle(1);
    check("wrap_down", 32'(bus.count), SAT_BUILD ? 32'd0 : 32'(MAXV));
`ifdef PRESS_COUNT_SATURATE_EN
    check("sat_pulse", 32'(sat_pulses - s0), 32'd1);
`endif

    // Priority: all three rise together with count at 5.
    press_clean(3'b100);
    for (int i = 0; i < 5; i++) press_clean(3'b001);
    settle(1);
    check("prio_start", 32'(bus.count), 32'd5);
    @(negedge clk);
    #2;
    set_btns(3'b111);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.grant !== 3'b000) seen = 1'b1;
    end
    check("prio_seen",   32'(seen),      32'd1);
    check("prio_grant1", 32'(bus.grant), 32'b100);
    check("prio_count1", 32'(bus.count), 32'd0);
    settle(1);
    check("prio_grant2", 32'(bus.grant), 32'b001);
    check("prio_count2", 32'(bus.count), 32'd1);
    settle(1);
    check("prio_grant3", 32'(bus.grant), 32'b010);
    check("prio_count3", 32'(bus.count), 32'd0);
    set_btns(3'b000);
    settle(12);

    // Same-edge re-request: a new up edge lands on the edge of the up grant.
    c0 = cnt_m;
    g0 = up_grants;
    @(negedge clk);
    #2;
    force dut.rise = 3'b001;
    force_rise_m = 3'b001;
    repeat (2) @(negedge clk);
    #2;
    release dut.rise;
    force_rise_m = 3'b000;
    settle(1);
    check("rereq_grant_held", 32'(bus.grant), 32'b001);
    settle(4);
    check("rereq_two_grants", 32'(up_grants - g0), 32'd2);
    check("rereq_count", 32'(bus.count), 32'((c0 + 2) % MODV));

    // Reset in the middle of a debounce: nothing is applied afterwards.
    @(negedge clk);
    #2;
    set_btns(3'b001);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_btns(3'b000);
    settle(12);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_pend",  32'(bus.pend),  32'd0);

    // Randomized bouncy traffic with occasional resets.
    for (int it = 0; it < 200; it++) begin
      logic [2:0] mask;
      int hold, gap;
      mask = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 10);
      gap  = $urandom_range(1, 10);
      @(negedge clk);
      #2;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 10; i++) begin
          set_btns((i % 2 == 0) ? mask : 3'($urandom_range(0, 7)));
          #5;
        end
      end
      set_btns(mask);
      repeat (hold) @(negedge clk);
      #2;
      set_btns(3'b000);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end
    end
    settle(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/press_count_ctrl.md
Name: press_count_ctrl

Overview:
- Debounce-and-arbitration controller for the shared press counter.
- Takes three raw, bouncy push-button inputs (up, down, clear) and synchronises and debounces each one.
- Turns each debounced rising edge into a pending request.
- A fixed-priority arbiter grants one request per cycle and applies it to the shared WIDTH-bit count register.
- Sits between board buttons and the display/count consumer; replaces per-button ad hoc counting.

Parameters:
- WIDTH, 4, bit width of the count register.
- DB_CYCLES, 4, consecutive identical synchronised samples needed to accept a new level (legal range 2..255).

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- btn_up  input  1  raw asynchronous, bouncy increment button.
- btn_down  input  1  raw asynchronous, bouncy decrement button.
- btn_clr  input  1  raw asynchronous, bouncy clear button.
- count  output  WIDTH  current count value.
- pend  output  3  pending request flags {clr, down, up}.
- grant  output  3  one-hot grant for the operation applied this cycle; all zero when idle.
- db_level  output  3  debounced levels {clr, down, up}.

Behaviour:
- Reset:
  - Sampled on clk rising edge while rst=1.
  - count=0, pend=0, grant=0, db_level=0.
  - Sync flops cleared, stability counters cleared.
  - Any in-flight pending requests are dropped.
- Synchroniser: two-flop synchroniser per button; s = second flop output.
- Debounce, per input:
  - Stability counter sc (8 bits).
  - If s == db_level: sc is held at 0.
  - Otherwise sc increments each cycle.
  - When sc reaches DB_CYCLES-1 while s is still != db_level, db_level takes s on that edge and sc returns to 0.
  - If s flips back before then, sc returns to 0.
  - Latency from a clean button edge to a db_level change = 2 sync cycles + DB_CYCLES cycles.
- Edge detect: a db_level 0->1 transition sets the matching pend bit on the same edge. A 1->0 transition does nothing.
- Arbiter:
  - Each cycle, grants the highest-priority set pend bit.
  - Priority: clr > up > down.
  - grant is registered: grant asserts for one cycle, and in that same cycle count is updated and the granted pend bit is cleared.
  - At most one operation per cycle.
  - Ungranted pend bits hold.
  - Requests are not queued beyond one per input: a second rising edge while the first is still pending is merged and lost.
- Simultaneous set and clear: if a new rising edge arrives on the same edge a bit's grant clears it, the pend bit stays set, so the new request is served later.
- Arithmetic:
  - up: count+1, modulo 2^WIDTH (15->0 at WIDTH=4).
  - down: count-1, modulo 2^WIDTH (0->15).
  - clr: count=0.
- Reset mid-debounce or mid-grant: all state returns to reset values; no operation is applied on the reset edge.

Optional Feature:
- Macro: PRESS_COUNT_SATURATE_EN.
- Defined:
  - up at all-ones leaves count unchanged; down at 0 leaves count unchanged.
  - The grant still pulses and the pend bit still clears.
  - An extra output port, sat (1 bit), pulses high for one cycle on any saturated (no-op) grant.
- Undefined:
  - Wrap-around arithmetic as above.
  - The sat port does not exist.

Decomposition:
- Shared package press_count_pkg holds:
  - Index constants IDX_UP=0, IDX_DOWN=1, IDX_CLR=2.
  - Constant NUM_BTN=3.
  - Debounce counter width constant SC_W=8.
- One natural sub-module, btn_debounce: synchroniser, stability counter, debounced level and rising-edge pulse. It is instantiated three times, parameterised by DB_CYCLES.

Test Plan:
- Reset: hold rst for 2 cycles with all buttons toggling -> count=0, pend=0, grant=0, db_level=0 throughout; no operation on release.
- Bouncy press: 40 ns clock; btn_up toggles every 5 ns for 50 ns, then is held high for 500 ns -> exactly one grant[0] pulse and count 0->1; repeating three times gives count=3.
- Short glitch: btn_down high for 2 cycles only -> db_level[1] stays 0 and count is unchanged.
- Wrap: 16 clean up presses from 0 -> count returns to 0. Then one down press -> count=15, or 0 with sat pulse when PRESS_COUNT_SATURATE_EN is defined.
- Priority: force debounced edges on up, down and clr in the same cycle with count=5 ->
  - Cycle 1: grant=100, count=0.
  - Cycle 2: grant=001, count=1.
  - Cycle 3: grant=010, count=0.
- Same-edge re-request: a new up edge coincides with the up grant -> a second grant[0] follows the next cycle; count rises by 2 in total.
